// File: rtl/cpu_pkg.sv
// Shared LEGv8 execute-stage types: branch kinds, B.cond codes and the NZCV flag layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_CBZ  = 3'd2,
    BR_CBNZ = 3'd3,
    BR_COND = 3'd4
  } br_kind_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator; kept standalone so predicated-select logic can share it.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  nzcv_t      i_flags,
  output logic       o_taken
);

  logic w_hi, w_ge, w_gt;

  assign w_hi = i_flags.c & ~i_flags.z;
  assign w_ge = (i_flags.n == i_flags.v);
  assign w_gt = ~i_flags.z & w_ge;

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = ~i_flags.z;
      COND_HS: o_taken = i_flags.c;
      COND_LO: o_taken = ~i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = ~i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = ~i_flags.v;
      COND_HI: o_taken = w_hi;
      COND_LS: o_taken = ~w_hi;
      COND_GE: o_taken = w_ge;
      COND_LT: o_taken = ~w_ge;
      COND_GT: o_taken = w_gt;
      COND_LE: o_taken = ~w_gt;
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// EX-stage branch resolver: NZCV flag register, registered redirect and a bounded
// squash window that blocks wrong-path branches and flag setters.
module branch_flag_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ex_valid,
  input  logic              i_stall,
  input  logic              i_set_flags,
  input  logic              i_alu_zero,
  input  logic              i_alu_neg,
  input  logic              i_alu_carry,
  input  logic              i_alu_ovf,
  input  logic [2:0]        i_br_kind,
  input  logic [3:0]        i_cond,
  input  logic              i_reg_zero,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic              o_br_taken,
  output logic [ADDR_W-1:0] o_pc_target,
  output logic              o_squash,
  output logic [3:0]        o_flags
);

  localparam logic [1:0] SQ_INIT = 2'(SQUASH_CYCLES);

  typedef enum logic {S_IDLE, S_SQUASH} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic              r_squash;
  logic              r_br_taken;
  logic [ADDR_W-1:0] r_pc_target;
  nzcv_t             r_flags;

  logic w_accept, w_cond_taken, w_taken;

  assign w_accept = i_ex_valid & ~i_stall & ~r_squash;

  // B.cond reads the registered flags; a setter never shares EX with a branch.
  cond_eval u_cond_eval (
    .i_cond  (i_cond),
    .i_flags (r_flags),
    .o_taken (w_cond_taken)
  );

  always_comb begin
    w_taken = 1'b0;
    if (w_accept) begin
      case (br_kind_t'(i_br_kind))
        BR_B:    w_taken = 1'b1;
        BR_CBZ:  w_taken = i_reg_zero;
        BR_CBNZ: w_taken = ~i_reg_zero;
        BR_COND: w_taken = w_cond_taken;
        default: w_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_taken) begin
          w_state_nxt = S_SQUASH;
          w_cnt_nxt   = SQ_INIT;
        end
      end
      S_SQUASH: begin
        if (!i_stall) begin
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_squash    <= 1'b0;
      r_br_taken  <= 1'b0;
      r_pc_target <= '0;
      r_flags     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_squash   <= (w_cnt_nxt != 2'd0);
      // Pulse clears even under stall; it can only be set by an accepted branch.
      r_br_taken <= w_taken;
      if (w_taken) r_pc_target <= i_br_target;
      if (w_accept && i_set_flags)
        r_flags <= {i_alu_neg, i_alu_zero, i_alu_carry, i_alu_ovf};
    end
  end

  assign o_br_taken  = r_br_taken;
  assign o_pc_target = r_pc_target;
  assign o_squash    = r_squash;
  assign o_flags     = r_flags;

endmodule
